// File: rtl/score_display_pkg.sv
// Shared definitions for the score-to-BCD conversion path: digit geometry,
// converter FSM states and the significant-digit counter.
package score_display_pkg;

  localparam int DIGITS = 10;
  localparam int BCD_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Number of digits the display must show: one past the highest nonzero
  // nibble, never less than one so a zero score still shows "0".
  function automatic logic [3:0] count_sig_digits(input logic [DIGITS*BCD_W-1:0] pending);
    logic [3:0] n;
    n = 4'd1;
    for (int k = 0; k < DIGITS; k++) begin
      if (pending[k*BCD_W +: BCD_W] != '0) begin
        n = 4'(k + 1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  // Inputs never exceed 9 here, so the 4-bit add cannot overflow.
  always_comb begin
    adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD converter for the score display. One score bit is
// shifted in per cycle; the finished digits are held back until a frame
// boundary so the displayed score never changes in the middle of a frame.
module score_bcd_converter #(
  parameter int SCORE_WIDTH    = 32,
  parameter int DIGITS         = 10,
  parameter bit AUTO_RECONVERT = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic                   start,
  input  logic                   frame_end,
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGITS-1:0]    digits,
  output logic [3:0]             num_digits
);

  import score_display_pkg::*;

  localparam int CNT_W     = $clog2(SCORE_WIDTH + 1);
  localparam int BCD_TOTAL = DIGITS * BCD_W;
  localparam int PKG_BCD_W = score_display_pkg::DIGITS * BCD_W;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SCORE_WIDTH-1:0] bin;
  logic [SCORE_WIDTH-1:0] last_score;
  logic [BCD_TOTAL-1:0]   bcd;
  logic [BCD_TOTAL-1:0]   pending;
  logic [BCD_TOTAL-1:0]   adjusted;
  logic [BCD_TOTAL-1:0]   bcd_next;
  logic [SCORE_WIDTH-1:0] bin_next;
  logic                   unused_carry;
  logic [PKG_BCD_W-1:0]   pending_ext;
  logic                   req;

  // One correction cell per digit, all applied in parallel before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .nibble   (bcd[g*BCD_W +: BCD_W]),
      .adjusted (adjusted[g*BCD_W +: BCD_W])
    );
  end

  // A conversion is wanted on an explicit start, or in auto mode whenever the
  // score has moved away from the value last converted.
  assign req = start | (AUTO_RECONVERT && (score != last_score));

  // Shift {bcd,bin} left by one; the bit leaving the top digit is dropped
  // because the digit count always covers the full score range.
  assign {unused_carry, bcd_next, bin_next} = {adjusted, bin, 1'b0};

  assign pending_ext = PKG_BCD_W'(pending);

  // Conversion FSM with registered busy/done/digits so outputs stay glitch-free
  // and stable between commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      digits     <= '0;
      num_digits <= 4'd1;
      last_score <= '0;
      bin        <= '0;
      bcd        <= '0;
      pending    <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            bin        <= score;
            last_score <= score;
            bcd        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= bcd_next;
          bin <= bin_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(SCORE_WIDTH - 1)) begin
            pending <= bcd_next;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (frame_end) begin
            digits     <= pending;
            num_digits <= count_sig_digits(pending_ext);
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter. Two instances share the clock: one
// with auto-reconvert off (explicit start only) and one with it on. Expected
// commits are queued when stimulus is issued and checked by per-instance
// monitors whenever done pulses.
module tb_score_bcd_converter;

  typedef struct {
    logic [39:0] digits;
    logic [3:0]  num;
  } exp_t;

  logic        clk;
  logic        reset0, start0, frame_end0, busy0, done0;
  logic [31:0] score0;
  logic [39:0] digits0;
  logic [3:0]  num0;
  logic        reset1, start1, frame_end1, busy1, done1;
  logic [31:0] score1;
  logic [39:0] digits1;
  logic [3:0]  num1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t exp0, exp1;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_count0 = 0;
  int   done_count1 = 0;

  score_bcd_converter #(.SCORE_WIDTH(32), .DIGITS(10), .AUTO_RECONVERT(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .score(score0), .start(start0), .frame_end(frame_end0),
    .busy(busy0), .done(done0), .digits(digits0), .num_digits(num0)
  );

  score_bcd_converter #(.SCORE_WIDTH(32), .DIGITS(10), .AUTO_RECONVERT(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .score(score1), .start(start1), .frame_end(frame_end1),
    .busy(busy1), .done(done1), .digits(digits1), .num_digits(num1)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case a bounded wait is ever bypassed
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done0(input int target);
    for (int i = 0; i < 5 && done_count0 < target; i++) cycle(1);
    check_output("done0_count", 64'(done_count0), 64'(target));
  endtask

  task automatic wait_done1(input int target);
    for (int i = 0; i < 5 && done_count1 < target; i++) cycle(1);
    check_output("done1_count", 64'(done_count1), 64'(target));
  endtask

  task automatic apply_stimulus0(input logic [31:0] s);
    score0 = s;
    start0 = 1'b1;
    cycle(1);
    start0 = 1'b0;
  endtask

  task automatic pulse_frame0();
    frame_end0 = 1'b1;
    cycle(1);
    frame_end0 = 1'b0;
  endtask

  task automatic pulse_frame1();
    frame_end1 = 1'b1;
    cycle(1);
    frame_end1 = 1'b0;
  endtask

  // Scoreboard monitor for the explicit-start instance
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        check_output("dut0_unexpected_done", 64'(done0), 64'd0);
      end else begin
        exp0 = q0.pop_front();
        check_output("dut0_digits", 64'(digits0), 64'(exp0.digits));
        check_output("dut0_num_digits", 64'(num0), 64'(exp0.num));
      end
      done_count0++;
    end
  end

  // Scoreboard monitor for the auto-reconvert instance
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        check_output("dut1_unexpected_done", 64'(done1), 64'd0);
      end else begin
        exp1 = q1.pop_front();
        check_output("dut1_digits", 64'(digits1), 64'(exp1.digits));
        check_output("dut1_num_digits", 64'(num1), 64'(exp1.num));
      end
      done_count1++;
    end
  end

  initial begin
    int bad_busy;
    int bad_digits;
    reset0 = 1'b1; start0 = 1'b0; frame_end0 = 1'b0; score0 = '0;
    reset1 = 1'b1; start1 = 1'b0; frame_end1 = 1'b0; score1 = '0;
    cycle(2);
    check_output("reset_busy", 64'(busy0), 64'd0);
    check_output("reset_done", 64'(done0), 64'd0);
    check_output("reset_digits", 64'(digits0), 64'd0);
    check_output("reset_num_digits", 64'(num0), 64'd1);
    reset0 = 1'b0;
    reset1 = 1'b0;
    cycle(1);

    // Zero score
    q0.push_back('{40'h0, 4'd1});
    apply_stimulus0(32'd0);
    check_output("busy_after_accept", 64'(busy0), 64'd1);
    cycle(40);
    pulse_frame0();
    wait_done0(1);

    // Largest score
    q0.push_back('{40'h4294967295, 4'd10});
    apply_stimulus0(32'hFFFF_FFFF);
    cycle(40);
    pulse_frame0();
    wait_done0(2);

    // No frame boundary for a long time: must stay busy and keep old digits
    apply_stimulus0(32'd1234);
    bad_busy = 0;
    bad_digits = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy0 !== 1'b1) bad_busy++;
      if (digits0 !== 40'h4294967295) bad_digits++;
      cycle(1);
    end
    check_output("hold_busy_errors", 64'(bad_busy), 64'd0);
    check_output("hold_digits_errors", 64'(bad_digits), 64'd0);
    q0.push_back('{40'h1234, 4'd4});
    pulse_frame0();
    check_output("commit_busy", 64'(busy0), 64'd0);
    check_output("commit_done", 64'(done0), 64'd1);
    wait_done0(3);

    // Start while busy is ignored
    q0.push_back('{40'h7, 4'd1});
    apply_stimulus0(32'd7);
    cycle(3);
    apply_stimulus0(32'd99);
    cycle(40);
    pulse_frame0();
    wait_done0(4);
    cycle(5);
    check_output("no_auto_restart", 64'(busy0), 64'd0);

    // Reset in the middle of a conversion discards it
    apply_stimulus0(32'd555);
    cycle(9);
    reset0 = 1'b1;
    cycle(1);
    check_output("midreset_busy", 64'(busy0), 64'd0);
    check_output("midreset_digits", 64'(digits0), 64'd0);
    check_output("midreset_num_digits", 64'(num0), 64'd1);
    check_output("midreset_done", 64'(done0), 64'd0);
    reset0 = 1'b0;
    cycle(40);
    pulse_frame0();
    cycle(3);
    check_output("no_done_after_reset", 64'(done_count0), 64'd4);

    // Auto mode: score change during WAIT triggers a fresh conversion
    q1.push_back('{40'h5, 4'd1});
    score1 = 32'd5;
    cycle(1);
    check_output("auto_accept", 64'(busy1), 64'd1);
    cycle(36);
    score1 = 32'd12;
    cycle(2);
    pulse_frame1();
    q1.push_back('{40'h12, 4'd2});
    check_output("auto_commit_done", 64'(done1), 64'd1);
    check_output("auto_commit_busy", 64'(busy1), 64'd0);
    cycle(1);
    check_output("auto_restart", 64'(busy1), 64'd1);
    // Strobe lands on the final shift edge and must be ignored
    cycle(31);
    pulse_frame1();
    check_output("coincident_busy", 64'(busy1), 64'd1);
    check_output("coincident_done", 64'(done1), 64'd0);
    cycle(5);
    check_output("still_waiting", 64'(busy1), 64'd1);
    check_output("coincident_done_count", 64'(done_count1), 64'd1);
    pulse_frame1();
    wait_done1(2);

    cycle(2);
    check_output("sb0_empty", 64'(q0.size()), 64'd0);
    check_output("sb1_empty", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
